// File: rtl/dsp_post_accum.sv
// dsp_post_accum: post-adder / accumulator stage of the DSP48A1 slice model.
// The stage picks the X and Z operands and adds or subtracts them with a
// carry-in. It produces the 48-bit P result, the carry-out and the PCOUT
// cascade. The internal P register always exists and is the feedback
// source for multiply-accumulate, whatever PREG is set to.
module dsp_post_accum #(
    parameter int CREG        = 1,
    parameter int OPMODEREG   = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CEC,
    input  logic               CEOPMODE,
    input  logic               CEP,
    input  logic signed [35:0] M,
    input  logic        [47:0] C,
    input  logic        [47:0] DAB,
    input  logic        [47:0] PCIN,
    input  logic        [5:0]  OPMODE,
    input  logic               CIN,
    output logic        [47:0] P,
    output logic        [47:0] PCOUT,
    output logic               CARRYOUT
);

    // Stage p0: operand/control input registers
    logic [47:0] r_c_p0;
    logic [4:0]  r_opmode_p0;
    logic        r_cin_p0;
    // Stage p1: result registers
    logic [47:0] r_p_p1;
    logic        r_carry_p1;

    logic [47:0] w_c;
    logic [4:0]  w_opmode;
    logic        w_cin;
    logic [47:0] w_m_ext;
    logic [47:0] w_x;
    logic [47:0] w_z;
    logic [48:0] w_r;
    logic        w_unused_opmode5;

    // 49-bit unsigned add or subtract. When subtracting, bit 48 is the borrow.
    function automatic logic [48:0] add_sub(
        input logic [47:0] z,
        input logic [47:0] x,
        input logic        cin,
        input logic        sub
    );
        logic [48:0] l_res;
        if (sub)
            l_res = {1'b0, z} - ({1'b0, x} + {48'd0, cin});
        else
            l_res = {1'b0, z} + {1'b0, x} + {48'd0, cin};
        return l_res;
    endfunction

    // C operand register, gated by CEC
    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_c_p0 <= '0;
        else if (CEC)
            r_c_p0 <= C;
    end

    // OPMODE/CIN register, gated by CEOPMODE; OPMODE[5] is reserved and not stored
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_opmode_p0 <= '0;
            r_cin_p0    <= 1'b0;
        end else if (CEOPMODE) begin
            r_opmode_p0 <= OPMODE[4:0];
            r_cin_p0    <= CIN;
        end
    end

    assign w_unused_opmode5 = OPMODE[5];

    assign w_c      = (CREG != 0)      ? r_c_p0      : C;
    assign w_opmode = (OPMODEREG != 0) ? r_opmode_p0 : OPMODE[4:0];
    assign w_cin    = (OPMODEREG != 0) ? r_cin_p0    : CIN;
    assign w_m_ext  = {{12{M[35]}}, M};

    // Operand muxes; feedback always comes from the internal P register
    always_comb begin
        w_x = '0;
        w_z = '0;
        case (w_opmode[1:0])
            2'b00: w_x = '0;
            2'b01: w_x = w_m_ext;
            2'b10: w_x = r_p_p1;
            default: w_x = DAB;
        endcase
        case (w_opmode[3:2])
            2'b00: w_z = '0;
            2'b01: w_z = PCIN;
            2'b10: w_z = r_p_p1;
            default: w_z = w_c;
        endcase
    end

    assign w_r = add_sub(w_z, w_x, w_cin, w_opmode[4]);

    // P and carry registers, gated by CEP; they exist in every configuration
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_p_p1     <= '0;
            r_carry_p1 <= 1'b0;
        end else if (CEP) begin
            r_p_p1     <= w_r[47:0];
            r_carry_p1 <= w_r[48];
        end
    end

    assign P        = (PREG != 0)        ? r_p_p1     : w_r[47:0];
    assign PCOUT    = P;
    assign CARRYOUT = (CARRYOUTREG != 0) ? r_carry_p1 : w_r[48];

endmodule

// File: tb/tb_dsp_post_accum.sv
// tb_dsp_post_accum: bench for dsp_post_accum. It drives a fully registered
// instance and a fully combinational instance from the same inputs.
module tb_dsp_post_accum;

    logic        CLK;
    logic        RST_N;
    logic        CEC, CEOPMODE, CEP;
    logic [35:0] M;
    logic [47:0] C, DAB, PCIN;
    logic [5:0]  OPMODE;
    logic        CIN;

    logic [47:0] p_r, pcout_r, p_c, pcout_c;
    logic        co_r, co_c;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [47:0] m_c;
    logic [5:0]  m_op;
    logic        m_cin;
    logic [47:0] m_p;
    logic        m_co;
    logic [47:0] m_pc;

    typedef struct {
        logic [5:0]  op;
        logic        cin;
        logic [35:0] m;
        logic [47:0] c;
        logic [47:0] dab;
        logic [47:0] pcin;
        logic [47:0] p;
        logic        co;
    } vec_t;

    vec_t tbl[8];

    dsp_post_accum #(.CREG(1), .OPMODEREG(1), .PREG(1), .CARRYOUTREG(1)) u_dut_reg (
        .CLK(CLK), .RST_N(RST_N), .CEC(CEC), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .M(M), .C(C), .DAB(DAB), .PCIN(PCIN), .OPMODE(OPMODE), .CIN(CIN),
        .P(p_r), .PCOUT(pcout_r), .CARRYOUT(co_r)
    );

    dsp_post_accum #(.CREG(0), .OPMODEREG(0), .PREG(0), .CARRYOUTREG(0)) u_dut_comb (
        .CLK(CLK), .RST_N(RST_N), .CEC(CEC), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .M(M), .C(C), .DAB(DAB), .PCIN(PCIN), .OPMODE(OPMODE), .CIN(CIN),
        .P(p_c), .PCOUT(pcout_c), .CARRYOUT(co_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Result of one add/sub in plain 64-bit arithmetic: {carry, P}
    function automatic logic [48:0] calc(input logic [5:0] op, input logic cin,
                                         input logic [47:0] c, input logic [35:0] m,
                                         input logic [47:0] dab, input logic [47:0] pcin,
                                         input logic [47:0] p);
        logic [63:0] x, z, r, msk;
        msk = 64'h0000_FFFF_FFFF_FFFF;
        case (op[1:0])
            2'd0: x = 64'd0;
            2'd1: x = longint'($signed(m)) & msk;
            2'd2: x = {16'd0, p};
            default: x = {16'd0, dab};
        endcase
        case (op[3:2])
            2'd0: z = 64'd0;
            2'd1: z = {16'd0, pcin};
            2'd2: z = {16'd0, p};
            default: z = {16'd0, c};
        endcase
        if (op[4]) r = z - x - 64'(cin);
        else       r = z + x + 64'(cin);
        return r[48:0];
    endfunction

    // Model of both instances' internal registers
    always @(posedge CLK) begin
        if (!RST_N) begin
            m_c <= '0; m_op <= '0; m_cin <= 1'b0;
            m_p <= '0; m_co <= 1'b0; m_pc <= '0;
        end else begin
            if (CEC)      m_c <= C;
            if (CEOPMODE) begin m_op <= OPMODE; m_cin <= CIN; end
            if (CEP) begin
                {m_co, m_p} <= calc(m_op, m_cin, m_c, M, DAB, PCIN, m_p);
                m_pc        <= calc(OPMODE, CIN, C, M, DAB, PCIN, m_pc)[47:0];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_inputs();
        M    = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
        C    = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        DAB  = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        PCIN = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        OPMODE = 6'($urandom);
        CIN  = 1'($urandom);
    endtask

    initial begin
        logic [48:0] e;
        tbl[0] = '{6'b001101, 1'b0, 36'd5, 48'd10, 48'd0, 48'd0, 48'd15, 1'b0};
        tbl[1] = '{6'b011111, 1'b0, 36'd0, 48'd1, 48'd2, 48'd0, 48'hFFFF_FFFF_FFFF, 1'b1};
        tbl[2] = '{6'b011111, 1'b1, 36'd0, 48'd5, 48'd2, 48'd0, 48'd2, 1'b0};
        tbl[3] = '{6'b000011, 1'b1, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b1};
        tbl[4] = '{6'b000101, 1'b0, 36'd7, 48'd0, 48'd0, 48'd8, 48'd15, 1'b0};
        tbl[5] = '{6'b100101, 1'b0, 36'd7, 48'd0, 48'd0, 48'd8, 48'd15, 1'b0};
        tbl[6] = '{6'b010001, 1'b0, 36'hF_FFFF_FFFD, 48'd0, 48'd0, 48'd0, 48'd3, 1'b1};
        tbl[7] = '{6'b000000, 1'b1, 36'd9, 48'd9, 48'd9, 48'd9, 48'd1, 1'b0};

        // Reset with random inputs and all enables on
        RST_N = 1'b0; CEC = 1'b1; CEOPMODE = 1'b1; CEP = 1'b1;
        rand_inputs();
        step();
        rand_inputs();
        step();
        chk("reset_p", 64'(p_r), 64'd0);
        chk("reset_pcout", 64'(pcout_r), 64'd0);
        chk("reset_co", 64'(co_r), 64'd0);

        // Table vectors: combinational instance at once, registered after two edges
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            OPMODE = tbl[i].op; CIN = tbl[i].cin; M = tbl[i].m;
            C = tbl[i].c; DAB = tbl[i].dab; PCIN = tbl[i].pcin;
            #1;
            chk($sformatf("vec%0d_comb_p", i), 64'(p_c), 64'(tbl[i].p));
            chk($sformatf("vec%0d_comb_pcout", i), 64'(pcout_c), 64'(tbl[i].p));
            chk($sformatf("vec%0d_comb_co", i), 64'(co_c), 64'(tbl[i].co));
            step();
            step();
            chk($sformatf("vec%0d_reg_p", i), 64'(p_r), 64'(tbl[i].p));
            chk($sformatf("vec%0d_reg_pcout", i), 64'(pcout_r), 64'(tbl[i].p));
            chk($sformatf("vec%0d_reg_co", i), 64'(co_r), 64'(tbl[i].co));
        end

        // MAC: reset mid-stream, then accumulate M=-3
        RST_N = 1'b0; OPMODE = 6'b001001; CIN = 1'b0; M = 36'hF_FFFF_FFFD;
        step();
        RST_N = 1'b1;
        step();
        chk("mac_oplatency_p", 64'(p_r), 64'd0);
        step();
        chk("mac_first_p", 64'(p_r), 64'h0000_FFFF_FFFF_FFFD);
        chk("mac_first_co", 64'(co_r), 64'd0);
        step();
        step();
        step();
        chk("mac_final_p", 64'(p_r), 64'h0000_FFFF_FFFF_FFF4);
        chk("mac_final_co", 64'(co_r), 64'd1);

        // CEP low holds P and carry while inputs change
        CEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            chk("hold_p", 64'(p_r), 64'h0000_FFFF_FFFF_FFF4);
            chk("hold_co", 64'(co_r), 64'd1);
        end
        RST_N = 1'b0;
        step();
        chk("rst_cep0_p", 64'(p_r), 64'd0);
        chk("rst_cep0_co", 64'(co_r), 64'd0);
        RST_N = 1'b1; CEP = 1'b1;
        step();

        // Randomized run against the reference model
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            CEC      = ($urandom_range(0, 3) != 0);
            CEOPMODE = ($urandom_range(0, 3) != 0);
            CEP      = ($urandom_range(0, 3) != 0);
            RST_N    = ($urandom_range(0, 24) != 0);
            #1;
            e = calc(OPMODE, CIN, C, M, DAB, PCIN, m_pc);
            chk("rnd_comb_p", 64'(p_c), 64'(e[47:0]));
            chk("rnd_comb_pcout", 64'(pcout_c), 64'(e[47:0]));
            chk("rnd_comb_co", 64'(co_c), 64'(e[48]));
            step();
            chk("rnd_reg_p", 64'(p_r), 64'(m_p));
            chk("rnd_reg_pcout", 64'(pcout_r), 64'(m_p));
            chk("rnd_reg_co", 64'(co_r), 64'(m_co));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
